// File: rtl/alu_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// alu_arbiter_ctrl
//   Round-robin arbiter and sequencer in front of one shared 8-bit
//   combinational ALU. It grants one of two requesters, latches that
//   requester's command and operands onto the ALU inputs, and holds them
//   for one EXEC cycle (plus MUL_LAT extra cycles for MUL). It then captures
//   the 16-bit ALU result and signals completion with a one-cycle done pulse.
//
// Parameters
//   MUL_LAT  extra EXEC cycles for MUL (cmd 4'b0100), 0..7
//   CNT_W    width of the EXEC hold counter, 2**CNT_W > MUL_LAT
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_in/cmdN_in/aN_in/bN_in  requester N level request, command, operands
//   gntN_out                 pulse: requester N operands latched
//   doneN_out                pulse: result_out valid for requester N
//   result_out               last captured ALU result
//   busy_out                 high whenever the FSM is not idle
//   alu_cmd/a/b_out, alu_oe_out  ALU drive (oe only in EXEC)
//   alu_d_in                 ALU result
//
// Optional feature (macro ALU_ARB_LOCK_EN)
//   Adds lock0_in/lock1_in, which are sampled at grant. A locked winner that
//   requests again in the first IDLE cycle after its RESP is re-granted.
//   This happens for at most 4 consecutive grants. After that the normal
//   round-robin order applies again.
// ----------------------------------------------------------------------------
module alu_arbiter_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_in,
    input  logic [3:0]  cmd0_in,
    input  logic [7:0]  a0_in,
    input  logic [7:0]  b0_in,
    input  logic        req1_in,
    input  logic [3:0]  cmd1_in,
    input  logic [7:0]  a1_in,
    input  logic [7:0]  b1_in,
`ifdef ALU_ARB_LOCK_EN
    input  logic        lock0_in,
    input  logic        lock1_in,
`endif
    output logic        gnt0_out,
    output logic        gnt1_out,
    output logic        done0_out,
    output logic        done1_out,
    output logic [15:0] result_out,
    output logic        busy_out,
    output logic [3:0]  alu_cmd_out,
    output logic [7:0]  alu_a_out,
    output logic [7:0]  alu_b_out,
    output logic        alu_oe_out,
    input  logic [15:0] alu_d_in
);

    localparam logic [3:0]       CMD_MUL = 4'b0100;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    // Id of the most recent winner; it doubles as the id of the op in flight.
    logic             last_gnt_r;

    logic             rr_grant_s;
    logic             rr_win_s;
    logic             grant_s;
    logic             win_s;
    logic [3:0]       sel_cmd_s;
    logic [7:0]       sel_a_s;
    logic [7:0]       sel_b_s;

`ifdef ALU_ARB_LOCK_EN
    localparam logic [2:0] LOCK_MAX = 3'd4;
    logic       lock_r;       // lock of the op in flight, sampled at grant
    logic       lock_pend_r;  // first IDLE cycle after a locked op's RESP
    logic [2:0] streak_r;     // consecutive grants to last_gnt_r, saturating
`endif

    // Round-robin choice: a lone request wins, a tie goes to the other side.
    always_comb begin
        rr_grant_s = 1'b0;
        rr_win_s   = 1'b0;
        if (req0_in && req1_in) begin
            rr_grant_s = 1'b1;
            rr_win_s   = ~last_gnt_r;
        end else if (req0_in) begin
            rr_grant_s = 1'b1;
            rr_win_s   = 1'b0;
        end else if (req1_in) begin
            rr_grant_s = 1'b1;
            rr_win_s   = 1'b1;
        end else begin
            rr_grant_s = 1'b0;
            rr_win_s   = 1'b0;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // A pending lock overrides round-robin if its owner is still requesting.
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (lock_pend_r && (streak_r < LOCK_MAX) &&
            (last_gnt_r ? req1_in : req0_in)) begin
            grant_s = 1'b1;
            win_s   = last_gnt_r;
        end else begin
            grant_s = rr_grant_s;
            win_s   = rr_win_s;
        end
    end
`else
    assign grant_s = rr_grant_s;
    assign win_s   = rr_win_s;
`endif

    // Operand mux for the selected winner.
    always_comb begin
        sel_cmd_s = win_s ? cmd1_in : cmd0_in;
        sel_a_s   = win_s ? a1_in   : a0_in;
        sel_b_s   = win_s ? b1_in   : b0_in;
    end

    // Sequencer FSM. Every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            last_gnt_r  <= 1'b1;
            gnt0_out    <= 1'b0;
            gnt1_out    <= 1'b0;
            done0_out   <= 1'b0;
            done1_out   <= 1'b0;
            result_out  <= 16'h0000;
            busy_out    <= 1'b0;
            alu_cmd_out <= 4'h0;
            alu_a_out   <= 8'h00;
            alu_b_out   <= 8'h00;
            alu_oe_out  <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_r      <= 1'b0;
            lock_pend_r <= 1'b0;
            streak_r    <= 3'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done0_out <= 1'b0;
                    done1_out <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
                    // The lock window lasts exactly this one IDLE cycle.
                    lock_pend_r <= 1'b0;
`endif
                    if (grant_s) begin
                        state_r     <= ST_EXEC;
                        busy_out    <= 1'b1;
                        alu_oe_out  <= 1'b1;
                        alu_cmd_out <= sel_cmd_s;
                        alu_a_out   <= sel_a_s;
                        alu_b_out   <= sel_b_s;
                        cnt_r       <= (sel_cmd_s == CMD_MUL) ? MUL_CNT : CNT_ZERO;
                        gnt0_out    <= ~win_s;
                        gnt1_out    <= win_s;
                        last_gnt_r  <= win_s;
`ifdef ALU_ARB_LOCK_EN
                        lock_r      <= win_s ? lock1_in : lock0_in;
                        if (win_s == last_gnt_r) begin
                            streak_r <= (streak_r == LOCK_MAX) ? LOCK_MAX : (streak_r + 3'd1);
                        end else begin
                            streak_r <= 3'd1;
                        end
`endif
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_out <= 1'b0;
                        gnt0_out <= 1'b0;
                        gnt1_out <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    gnt0_out <= 1'b0;
                    gnt1_out <= 1'b0;
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        result_out <= alu_d_in;
                        state_r    <= ST_RESP;
                        alu_oe_out <= 1'b0;
                        done0_out  <= ~last_gnt_r;
                        done1_out  <= last_gnt_r;
                    end
                end
                ST_RESP: begin
                    done0_out <= 1'b0;
                    done1_out <= 1'b0;
                    busy_out  <= 1'b0;
                    state_r   <= ST_IDLE;
`ifdef ALU_ARB_LOCK_EN
                    lock_pend_r <= lock_r;
`endif
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_out   <= 1'b0;
                    alu_oe_out <= 1'b0;
                    gnt0_out   <= 1'b0;
                    gnt1_out   <= 1'b0;
                    done0_out  <= 1'b0;
                    done1_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter_ctrl
//   Scoreboard bench for alu_arbiter_ctrl. The stimulus pushes the expected
//   grants and completions, including their cycle numbers and result values.
//   A monitor pops and compares them whenever the DUT pulses gnt or done.
//   The bench includes a small ALU model that feeds alu_d_in.
// ----------------------------------------------------------------------------
module tb_alu_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  cmd0 = 4'h0, cmd1 = 4'h0;
    logic [7:0]  a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic        gnt0, gnt1, done0, done1, busy, alu_oe;
    logic [15:0] result, alu_d;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_a, alu_b;
`ifdef ALU_ARB_LOCK_EN
    logic        lock0 = 1'b0, lock1 = 1'b0;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int oe_run = 0;

    typedef struct { logic id; logic [15:0] res; int cyc; int oe; } done_exp_t;
    typedef struct { logic id; int cyc; } gnt_exp_t;
    done_exp_t done_q[$];
    gnt_exp_t  gnt_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_ctrl #(.MUL_LAT(2), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_in(req0), .cmd0_in(cmd0), .a0_in(a0), .b0_in(b0),
        .req1_in(req1), .cmd1_in(cmd1), .a1_in(a1), .b1_in(b1),
`ifdef ALU_ARB_LOCK_EN
        .lock0_in(lock0), .lock1_in(lock1),
`endif
        .gnt0_out(gnt0), .gnt1_out(gnt1), .done0_out(done0), .done1_out(done1),
        .result_out(result), .busy_out(busy),
        .alu_cmd_out(alu_cmd), .alu_a_out(alu_a), .alu_b_out(alu_b),
        .alu_oe_out(alu_oe), .alu_d_in(alu_d)
    );

    // Shared-ALU model: ADD, SUB, MUL, anything else concatenates a and b.
    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'b0000: alu_f = {8'h00, a} + {8'h00, b};
            4'b0001: alu_f = {8'h00, a} - {8'h00, b};
            4'b0100: alu_f = {8'h00, a} * {8'h00, b};
            default: alu_f = {a, b};
        endcase
    endfunction

    assign alu_d = alu_oe ? alu_f(alu_cmd, alu_a, alu_b) : 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every gnt and done pulse against the scoreboard.
    initial begin
        gnt_exp_t  g;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (!rst_n) oe_run = 0;
            else if (alu_oe) oe_run++;
            if (gnt0 || gnt1) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", {gnt1, gnt0}, 2'b00);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt_id", {gnt1, gnt0}, g.id ? 2'b10 : 2'b01);
                    chk("gnt_cycle", cyc, g.cyc);
                end
            end
            if (done0 || done1) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {done1, done0}, 2'b00);
                end else begin
                    d = done_q.pop_front();
                    chk("done_id", {done1, done0}, d.id ? 2'b10 : 2'b01);
                    chk("done_result", result, d.res);
                    chk("done_cycle", cyc, d.cyc);
                    chk("oe_cycles", oe_run, d.oe);
                end
                oe_run = 0;
            end
        end
    end

    task automatic drive(input logic id, input logic r, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        if (id) begin req1 = r; cmd1 = c; a1 = a; b1 = b; end
        else    begin req0 = r; cmd0 = c; a0 = a; b0 = b; end
    endtask

    task automatic wait_gnt(input logic id);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) return;
        end
        chk("gnt_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // One isolated operation; operands are scrambled right after the grant.
    task automatic issue_op(input logic id, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] res, input int k);
        gnt_q.push_back('{id, cyc + 1});
        done_q.push_back('{id, res, cyc + 2 + k, k + 1});
        drive(id, 1'b1, c, a, b);
        wait_gnt(id);
        drive(id, 1'b0, ~c, ~a, ~b);
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_oe"}, alu_oe, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_alu_bus"}, {alu_cmd, alu_a, alu_b}, 0);
        chk({tag, "_pulses"}, {gnt0, gnt1, done0, done1}, 0);
    endtask

    initial begin
        int c, n0, n1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset");

        issue_op(1'b0, 4'b0000, 8'h0F, 8'h01, 16'h0010, 0);
        issue_op(1'b0, 4'b0100, 8'h10, 8'h10, 16'h0100, 2);
        issue_op(1'b0, 4'b0100, 8'hFF, 8'hFF, 16'hFE01, 2);
        issue_op(1'b1, 4'b0001, 8'h20, 8'h05, 16'h001B, 0);
        issue_op(1'b0, 4'b0101, 8'hA5, 8'h5A, 16'hA55A, 0);
        issue_op(1'b1, 4'b1111, 8'h12, 8'h34, 16'h1234, 0);

        // Both requesters held: last grant was 1, so the order is 0,1,0,1.
        c = cyc;
        gnt_q.push_back('{1'b0, c + 1});  gnt_q.push_back('{1'b1, c + 4});
        gnt_q.push_back('{1'b0, c + 7});  gnt_q.push_back('{1'b1, c + 10});
        done_q.push_back('{1'b0, 16'h0003, c + 2, 1});
        done_q.push_back('{1'b1, 16'hFFFF, c + 5, 1});
        done_q.push_back('{1'b0, 16'h0100, c + 8, 1});
        done_q.push_back('{1'b1, 16'h01FE, c + 11, 1});
        drive(1'b0, 1'b1, 4'b0000, 8'h01, 8'h02);
        drive(1'b1, 1'b1, 4'b0001, 8'h03, 8'h04);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 60 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge clk);
            if (gnt0) begin
                n0++;
                if (n0 == 1) drive(1'b0, 1'b1, 4'b0000, 8'h80, 8'h80);
                else req0 = 1'b0;
            end
            if (gnt1) begin
                n1++;
                if (n1 == 1) drive(1'b1, 1'b1, 4'b0000, 8'hFF, 8'hFF);
                else req1 = 1'b0;
            end
        end
        chk("alternate_grants", {n0[7:0], n1[7:0]}, 16'h0202);
        wait_idle();

        // Reset in EXEC of a requester-1 SUB: no done1 may follow.
        gnt_q.push_back('{1'b1, cyc + 1});
        drive(1'b1, 1'b1, 4'b0001, 8'h30, 8'h10);
        wait_gnt(1'b1);
        req1 = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue_op(1'b0, 4'b0000, 8'h05, 8'h06, 16'h000B, 0);

`ifdef ALU_ARB_LOCK_EN
        // Lock on requester 0: four grants to 0, then the tie goes to 1.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back('{1'b0, c + 1 + 3 * i});
            done_q.push_back('{1'b0, 16'h0002, c + 2 + 3 * i, 1});
        end
        gnt_q.push_back('{1'b1, c + 13});
        done_q.push_back('{1'b1, 16'h0004, c + 14, 1});
        lock0 = 1'b1;
        drive(1'b0, 1'b1, 4'b0000, 8'h01, 8'h01);
        drive(1'b1, 1'b1, 4'b0000, 8'h02, 8'h02);
        n1 = 0;
        for (int i = 0; i < 60 && n1 == 0; i++) begin
            @(negedge clk);
            if (gnt1) begin
                n1 = 1;
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("lock_release_grant", n1, 1);
        lock0 = 1'b0;
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", done_q.size() + gnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
